// File: rtl/sdram_init_pkg.sv
// -----------------------------------------------------------------------------
// sdram_init_pkg
// Shared definitions for the SDRAM power-up initialization monitor:
//   - command encodings {cs_n, ras_n, cas_n, we_n} (also used by the
//     controller's init block)
//   - monitor state enum
//   - error-code constants (0 = no error)
//   - mode_ok(): legality check of the CL / BL / BT mode-register fields
// -----------------------------------------------------------------------------
package sdram_init_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  typedef enum logic [3:0] {
    ST_PWR,
    ST_WAIT_PRE,
    ST_TRP,
    ST_WAIT_AR,
    ST_TRFC,
    ST_WAIT_MRS,
    ST_TMRD,
    ST_READY,
    ST_ERR
  } mon_state_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_EARLY_CMD = 3'd1;
  localparam logic [2:0] ERR_BAD_PRE   = 3'd2;
  localparam logic [2:0] ERR_TIMING    = 3'd3;
  localparam logic [2:0] ERR_ORDER     = 3'd4;
  localparam logic [2:0] ERR_BAD_MODE  = 3'd5;
  localparam logic [2:0] ERR_EXTRA_AR  = 3'd6;

  // mr = MR[6:0]: CL must be 2 or 3, BL codes 4..6 are reserved,
  // and full-page burst (BL=7) only exists for sequential burst type.
  function automatic logic mode_ok(input logic [6:0] mr);
    logic [2:0] bl;
    logic       bt;
    logic [2:0] cl;
    bl = mr[2:0];
    bt = mr[3];
    cl = mr[6:4];
    mode_ok = 1'b1;
    if ((cl != 3'd2) && (cl != 3'd3)) mode_ok = 1'b0;
    if ((bl == 3'd4) || (bl == 3'd5) || (bl == 3'd6)) mode_ok = 1'b0;
    if ((bl == 3'd7) && bt) mode_ok = 1'b0;
  endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// -----------------------------------------------------------------------------
// sdram_wait_cnt
// Loadable down-counter with a zero flag. Load has priority over decrement;
// decrement stops at zero.
// Ports:
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset (counter clears to 0)
//   load_i      load load_val_i this cycle
//   load_val_i  value to load
//   dec_i       decrement by one (ignored at zero)
//   cnt_o       current count
//   zero_o      count is zero
// -----------------------------------------------------------------------------
module sdram_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_mon.sv
// -----------------------------------------------------------------------------
// sdram_init_mon
// Device-side monitor for the SDRAM power-up initialization sequence:
// power-up wait, precharge-all, AR_NUM auto-refreshes, mode-register set.
// Enforces tRP/tRFC/tMRD spacing, latches the programmed mode register and
// raises mon_ready, or latches a sticky error with the first error cause.
//
// Parameters: T_PWR, T_RP, T_RFC, T_MRD (cycles), AR_NUM (refresh count).
// Ports:
//   mon_clk         clock, rising edge
//   mon_rst_n       asynchronous active-low reset
//   mon_cmd[3:0]    {cs_n, ras_n, cas_n, we_n}; cs_n=1 counts as NOP
//   mon_bank[1:0]   bank address (observed only)
//   mon_addr[12:0]  address; A10 = precharge-all
//   mon_ready       init complete, mode fields valid
//   mon_err         sticky protocol error
//   mon_err_code    first error cause (0 = none)
//   mon_burst_len   MR[2:0]
//   mon_burst_type  MR[3]
//   mon_cas_lat     MR[6:4]
//   mon_wr_single   MR[9]
//
// Build option: SDRAM_MON_EXTRA_AR_EN -- when defined, an AR while waiting for
// MRS is accepted (re-enters tRFC); otherwise it is error code 6.
// -----------------------------------------------------------------------------
module sdram_init_mon
  import sdram_init_pkg::*;
#(
  parameter int T_PWR  = 20000,
  parameter int T_RP   = 2,
  parameter int T_RFC  = 7,
  parameter int T_MRD  = 3,
  parameter int AR_NUM = 8
) (
  input  logic        mon_clk,
  input  logic        mon_rst_n,
  input  logic [3:0]  mon_cmd,
  input  logic [1:0]  mon_bank,
  input  logic [12:0] mon_addr,
  output logic        mon_ready,
  output logic        mon_err,
  output logic [2:0]  mon_err_code,
  output logic [2:0]  mon_burst_len,
  output logic        mon_burst_type,
  output logic [2:0]  mon_cas_lat,
  output logic        mon_wr_single
);

  localparam int T_MAX_A = (T_PWR > T_RFC) ? T_PWR : T_RFC;
  localparam int T_MAX_B = (T_RP > T_MRD) ? T_RP : T_MRD;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX + 1);
  localparam int AW      = $clog2(AR_NUM + 1);

  mon_state_e  state_q, state_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic [AW-1:0] ar_q, ar_d, ar_inc;
  logic [2:0]  bl_q, bl_d;
  logic        bt_q, bt_d;
  logic [2:0]  cl_q, cl_d;
  logic        ws_q, ws_d;

  logic          cnt_ld, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_val, cnt_q;

  logic        is_nop, is_pre, is_ar, is_mrs;
  logic [2:0]  fault;

  // Window request: enter win_st with counter T-1, or go straight to win_nx
  // when T <= 1 (no wait cycle).
  logic        win_go;
  int          win_len;
  mon_state_e  win_st, win_nx;

  // Bank and unused address bits are not part of the init protocol checks.
  logic unused_ok;
  assign unused_ok = ^{mon_bank, mon_addr[12:11], mon_addr[8:7]};

  sdram_wait_cnt #(.W(CW)) u_wait_cnt (
    .clk_i      (mon_clk),
    .rst_n_i    (mon_rst_n),
    .load_i     (cnt_ld),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_q),
    .zero_o     (cnt_zero)
  );

  assign is_nop = mon_cmd[3] || (mon_cmd == CMD_NOP);
  assign is_pre = (mon_cmd == CMD_PRE);
  assign is_ar  = (mon_cmd == CMD_AR);
  assign is_mrs = (mon_cmd == CMD_MRS);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    code_d  = code_q;
    ar_d    = ar_q;
    bl_d    = bl_q;
    bt_d    = bt_q;
    cl_d    = cl_q;
    ws_d    = ws_q;
    fault   = ERR_NONE;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    cnt_dec = 1'b0;
    win_go  = 1'b0;
    win_len = 0;
    win_st  = state_q;
    win_nx  = state_q;
    ar_inc  = (ar_q == AW'(AR_NUM)) ? ar_q : ar_q + AW'(1);

    case (state_q)
      ST_PWR: begin
        if (!is_nop) begin
          fault = ERR_EARLY_CMD;
        end else if (cnt_zero) begin
          // Only zero on the first cycle after reset release.
          win_go  = 1'b1;
          win_len = T_PWR;
          win_st  = ST_PWR;
          win_nx  = ST_WAIT_PRE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_q == CW'(1)) state_d = ST_WAIT_PRE;
        end
      end
      ST_WAIT_PRE: begin
        if (is_pre) begin
          if (mon_addr[10]) begin
            win_go  = 1'b1;
            win_len = T_RP;
            win_st  = ST_TRP;
            win_nx  = ST_WAIT_AR;
          end else begin
            fault = ERR_BAD_PRE;
          end
        end else if (!is_nop) begin
          fault = ERR_ORDER;
        end
      end
      ST_TRP: begin
        if (!is_nop) begin
          fault = ERR_TIMING;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_q == CW'(1)) state_d = ST_WAIT_AR;
        end
      end
      ST_WAIT_AR: begin
        if (is_ar) begin
          ar_d    = ar_inc;
          win_go  = 1'b1;
          win_len = T_RFC;
          win_st  = ST_TRFC;
          win_nx  = (ar_inc < AW'(AR_NUM)) ? ST_WAIT_AR : ST_WAIT_MRS;
        end else if (!is_nop) begin
          fault = ERR_ORDER;
        end
      end
      ST_TRFC: begin
        if (!is_nop) begin
          fault = ERR_TIMING;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = (ar_q < AW'(AR_NUM)) ? ST_WAIT_AR : ST_WAIT_MRS;
          end
        end
      end
      ST_WAIT_MRS, ST_READY: begin
        if (is_mrs) begin
          if (!mode_ok(mon_addr[6:0])) begin
            fault = ERR_BAD_MODE;
          end else begin
            bl_d    = mon_addr[2:0];
            bt_d    = mon_addr[3];
            cl_d    = mon_addr[6:4];
            ws_d    = mon_addr[9];
            win_go  = 1'b1;
            win_len = T_MRD;
            win_st  = ST_TMRD;
            win_nx  = ST_READY;
          end
        end else if (state_q == ST_WAIT_MRS) begin
          if (is_ar) begin
`ifdef SDRAM_MON_EXTRA_AR_EN
            // ar_cnt is already saturated, so tRFC exit returns here.
            ar_d    = ar_inc;
            win_go  = 1'b1;
            win_len = T_RFC;
            win_st  = ST_TRFC;
            win_nx  = ST_WAIT_MRS;
`else
            fault = ERR_EXTRA_AR;
`endif
          end else if (!is_nop) begin
            fault = ERR_ORDER;
          end
        end
        // In READY, PRE/AR are accepted and anything else is ignored.
      end
      ST_TMRD: begin
        if (!is_nop) begin
          fault = ERR_TIMING;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_q == CW'(1)) state_d = ST_READY;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase

    if (win_go) begin
      if (win_len <= 1) begin
        state_d = win_nx;
      end else begin
        cnt_ld  = 1'b1;
        cnt_val = CW'(win_len - 1);
        state_d = win_st;
      end
    end

    // ERR is absorbing, so the first cause recorded is never overwritten.
    if (fault != ERR_NONE) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      code_d  = fault;
    end

    // Ready only while settled in READY; an MRS drops it on its own edge.
    ready_d = (state_q == ST_READY) && (state_d == ST_READY);
  end

  always_ff @(posedge mon_clk or negedge mon_rst_n) begin
    if (!mon_rst_n) begin
      state_q <= ST_PWR;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ar_q    <= '0;
      bl_q    <= 3'd0;
      bt_q    <= 1'b0;
      cl_q    <= 3'd0;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ar_q    <= ar_d;
      bl_q    <= bl_d;
      bt_q    <= bt_d;
      cl_q    <= cl_d;
      ws_q    <= ws_d;
    end
  end

  assign mon_ready      = ready_q;
  assign mon_err        = err_q;
  assign mon_err_code   = code_q;
  assign mon_burst_len  = bl_q;
  assign mon_burst_type = bt_q;
  assign mon_cas_lat    = cl_q;
  assign mon_wr_single  = ws_q;

endmodule

// File: tb/tb_sdram_init_mon.sv
// -----------------------------------------------------------------------------
// tb_sdram_init_mon
// Directed bench for sdram_init_mon with T_PWR=100, T_RP=2, T_RFC=7, T_MRD=3,
// AR_NUM=8. Inputs change on the falling edge; outputs are sampled on the
// falling edge after each rising edge. The first rising edge after reset
// release is cycle 0.
// -----------------------------------------------------------------------------
module tb_sdram_init_mon;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [3:0] ACT = 4'b0011;

  logic        mon_clk;
  logic        mon_rst_n;
  logic [3:0]  mon_cmd;
  logic [1:0]  mon_bank;
  logic [12:0] mon_addr;
  logic        mon_ready;
  logic        mon_err;
  logic [2:0]  mon_err_code;
  logic [2:0]  mon_burst_len;
  logic        mon_burst_type;
  logic [2:0]  mon_cas_lat;
  logic        mon_wr_single;

  int checks;
  int errors;

  sdram_init_mon #(
    .T_PWR (100),
    .T_RP  (2),
    .T_RFC (7),
    .T_MRD (3),
    .AR_NUM(8)
  ) dut (
    .mon_clk        (mon_clk),
    .mon_rst_n      (mon_rst_n),
    .mon_cmd        (mon_cmd),
    .mon_bank       (mon_bank),
    .mon_addr       (mon_addr),
    .mon_ready      (mon_ready),
    .mon_err        (mon_err),
    .mon_err_code   (mon_err_code),
    .mon_burst_len  (mon_burst_len),
    .mon_burst_type (mon_burst_type),
    .mon_cas_lat    (mon_cas_lat),
    .mon_wr_single  (mon_wr_single)
  );

  initial mon_clk = 1'b0;
  always #5 mon_clk = ~mon_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command at the next rising edge, then back to NOP at the falling edge.
  task automatic cyc(input logic [3:0] c, input logic [12:0] a);
    mon_cmd  = c;
    mon_addr = a;
    mon_bank = 2'b00;
    @(posedge mon_clk);
    @(negedge mon_clk);
    mon_cmd  = NOP;
    mon_addr = 13'h0;
  endtask

  task automatic nop(input int n);
    repeat (n) cyc(NOP, 13'h0);
  endtask

  task automatic rst_assert();
    mon_cmd   = NOP;
    mon_addr  = 13'h0;
    mon_rst_n = 1'b0;
    #1;
  endtask

  task automatic rst_release();
    @(negedge mon_clk);
    @(negedge mon_clk);
    mon_rst_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_assert();
    rst_release();
  endtask

  // Power-up wait, PRE-all at cycle 100, 8 ARs 7 cycles apart; ends in WAIT_MRS.
  task automatic init_to_mrs();
    nop(100);
    cyc(PRE, 13'h400);
    nop(1);
    repeat (8) begin
      cyc(AR, 13'h0);
      nop(6);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mon_rst_n = 1'b1;
    mon_cmd   = NOP;
    mon_bank  = 2'b00;
    mon_addr  = 13'h0;
    @(negedge mon_clk);

    // Reset state
    rst_assert();
    chk("rst_ready", 16'(mon_ready), 16'd0);
    chk("rst_err",   16'(mon_err), 16'd0);
    chk("rst_code",  16'(mon_err_code), 16'd0);
    chk("rst_mode",  16'({mon_burst_len, mon_burst_type, mon_cas_lat, mon_wr_single}), 16'd0);
    rst_release();

    // Legal sequence, MRS 0x032: CL=3, BL=2, BT=0
    init_to_mrs();
    cyc(MRS, 13'h032);
    nop(2);
    chk("legal_ready_mrs+2", 16'(mon_ready), 16'd0);
    nop(1);
    chk("legal_ready_mrs+3", 16'(mon_ready), 16'd1);
    chk("legal_err",  16'(mon_err), 16'd0);
    chk("legal_code", 16'(mon_err_code), 16'd0);
    chk("legal_cl",   16'(mon_cas_lat), 16'd3);
    chk("legal_bl",   16'(mon_burst_len), 16'd2);
    chk("legal_bt",   16'(mon_burst_type), 16'd0);
    chk("legal_ws",   16'(mon_wr_single), 16'd0);

    // Re-MRS in READY (0x03A: BT=1): ready drops, returns after tMRD
    cyc(MRS, 13'h03A);
    chk("remrs_ready_drop", 16'(mon_ready), 16'd0);
    nop(2);
    chk("remrs_ready_mrs+2", 16'(mon_ready), 16'd0);
    nop(1);
    chk("remrs_ready_mrs+3", 16'(mon_ready), 16'd1);
    chk("remrs_bt", 16'(mon_burst_type), 16'd1);
    cyc(ACT, 13'h0);
    cyc(PRE, 13'h0);
    cyc(AR, 13'h0);
    chk("ready_ignore_err", 16'(mon_err), 16'd0);
    chk("ready_ignore_rdy", 16'(mon_ready), 16'd1);

    // Full-page burst with interleaved type in READY (0x03F) -> code 5, fields hold
    cyc(MRS, 13'h03F);
    chk("fullpage_bt_err",  16'(mon_err), 16'd1);
    chk("fullpage_bt_code", 16'(mon_err_code), 16'd5);
    chk("fullpage_bt_rdy",  16'(mon_ready), 16'd0);
    chk("fullpage_bt_hold", 16'({mon_burst_len, mon_burst_type, mon_cas_lat}), 16'({3'd2, 1'b1, 3'd3}));

    // AR at cycle 50 during power-up -> code 1
    do_reset();
    nop(50);
    cyc(AR, 13'h0);
    chk("early_err",  16'(mon_err), 16'd1);
    chk("early_code", 16'(mon_err_code), 16'd1);
    nop(60);
    chk("early_sticky_code", 16'(mon_err_code), 16'd1);
    chk("early_ready", 16'(mon_ready), 16'd0);

    // PRE at cycle 99 (last power-up cycle) -> code 1
    do_reset();
    nop(99);
    cyc(PRE, 13'h400);
    chk("pwr_edge_code", 16'(mon_err_code), 16'd1);

    // AR one cycle after PRE (tRP=2) -> code 3
    do_reset();
    nop(100);
    cyc(PRE, 13'h400);
    cyc(AR, 13'h0);
    chk("trp_code", 16'(mon_err_code), 16'd3);

    // Second AR 6 cycles after the first -> code 3; later MRS changes nothing
    do_reset();
    nop(100);
    cyc(PRE, 13'h400);
    nop(1);
    cyc(AR, 13'h0);
    nop(5);
    cyc(AR, 13'h0);
    chk("trfc_err",  16'(mon_err), 16'd1);
    chk("trfc_code", 16'(mon_err_code), 16'd3);
    nop(10);
    cyc(MRS, 13'h032);
    nop(3);
    chk("trfc_sticky_code", 16'(mon_err_code), 16'd3);
    chk("trfc_no_ready", 16'(mon_ready), 16'd0);
    chk("trfc_cl_hold", 16'(mon_cas_lat), 16'd0);

    // MRS with CL=1 -> code 5
    do_reset();
    init_to_mrs();
    cyc(MRS, 13'h012);
    chk("badcl_err",  16'(mon_err), 16'd1);
    chk("badcl_code", 16'(mon_err_code), 16'd5);
    nop(3);
    chk("badcl_ready", 16'(mon_ready), 16'd0);

    // PRE with A10=0 -> code 2
    do_reset();
    nop(100);
    cyc(PRE, 13'h000);
    chk("badpre_code", 16'(mon_err_code), 16'd2);

    // Ninth AR while waiting for MRS
    do_reset();
    init_to_mrs();
    cyc(AR, 13'h0);
`ifdef SDRAM_MON_EXTRA_AR_EN
    chk("extra_ar_err", 16'(mon_err), 16'd0);
    nop(6);
    cyc(MRS, 13'h032);
    nop(3);
    chk("extra_ar_ready", 16'(mon_ready), 16'd1);
    chk("extra_ar_code", 16'(mon_err_code), 16'd0);
`else
    chk("extra_ar_err",  16'(mon_err), 16'd1);
    chk("extra_ar_code", 16'(mon_err_code), 16'd6);
    nop(6);
    cyc(MRS, 13'h032);
    nop(3);
    chk("extra_ar_ready", 16'(mon_ready), 16'd0);
`endif

    // Reset pulsed during tRFC, then a full legal sequence with MRS 0x223
    do_reset();
    nop(100);
    cyc(PRE, 13'h400);
    nop(1);
    cyc(AR, 13'h0);
    nop(6);
    cyc(AR, 13'h0);
    nop(2);
    rst_assert();
    chk("midrst_err",   16'(mon_err), 16'd0);
    chk("midrst_ready", 16'(mon_ready), 16'd0);
    rst_release();
    init_to_mrs();
    cyc(MRS, 13'h223);
    nop(3);
    chk("after_rst_ready", 16'(mon_ready), 16'd1);
    chk("after_rst_code",  16'(mon_err_code), 16'd0);
    chk("after_rst_bl",    16'(mon_burst_len), 16'd3);
    chk("after_rst_cl",    16'(mon_cas_lat), 16'd2);
    chk("after_rst_bt",    16'(mon_burst_type), 16'd0);
    chk("after_rst_ws",    16'(mon_wr_single), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
